// File: rtl/wshb_rr_arbiter_if.sv
// Bus bundle between NM Wishbone classic masters, the arbiter and the single SDRAM slave.
// slave = arbiter view (takes master requests, drives slave port); master = system view.
interface wshb_rr_arbiter_if #(
   parameter int NM = 2,
   parameter int AW = 32
);
   logic [NM-1:0]    m_cyc, m_stb, m_we;
   logic [NM*AW-1:0] m_adr;
   logic [NM*4-1:0]  m_sel;
   logic [NM*32-1:0] m_dat_ms;
   logic [NM-1:0]    m_ack, m_err;
   logic [31:0]      m_dat_sm;
   logic             s_cyc, s_stb, s_we;
   logic [AW-1:0]    s_adr;
   logic [3:0]       s_sel;
   logic [31:0]      s_dat_ms;
   logic             s_ack, s_err;
   logic [31:0]      s_dat_sm;

   modport slave (
      input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms,
      output m_ack, m_err, m_dat_sm,
      output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms,
      input  s_ack, s_err, s_dat_sm
   );

   modport master (
      output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms,
      input  m_ack, m_err, m_dat_sm,
      input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms,
      output s_ack, s_err, s_dat_sm
   );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NM masters share one SDRAM slave, bursts capped at MAX_BURST.
// Define WSHB_ARB_STATS_EN to build the per-master acked-beat counters on stat_beats.
module wshb_rr_arbiter #(
   parameter int NM        = 2,
   parameter int AW        = 32,
   parameter int MAX_BURST = 64
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   wshb_rr_arbiter_if.slave        bus,
   output logic [NM-1:0]           gnt,
   output logic [NM*16-1:0]        stat_beats
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int PW = (NM > 1) ? $clog2(NM) : 1;
   localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [PW-1:0] ptr, owner, idx;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [NM-1:0] pick, others;
   logic          found, beat, rel;

   // First requester at or after ptr, wrapping modulo NM.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NM; k++) begin
         idx = PW'((int'(ptr) + k) % NM);
         if (!found && bus.m_cyc[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      owner = '0;
      for (int i = 0; i < NM; i++)
         if (gnt[i]) owner = PW'(i);
   end

   assign beat    = (state == GRANT) && (bus.s_ack || bus.s_err);
   assign cnt_nxt = (beat && cnt != CMAX) ? cnt + 1'b1 : cnt;
   assign others  = bus.m_cyc & ~gnt;
   // Release only on a completed beat or on cyc drop, so no beat is ever left in flight.
   assign rel     = (state == GRANT) &&
                    (!(|(gnt & bus.m_cyc)) || (beat && cnt_nxt == CMAX && |others));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.m_cyc) begin
                  gnt   <= pick;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (rel) begin
                  state <= IDLE;
                  gnt   <= '0;
                  cnt   <= '0;
                  ptr   <= (owner == PW'(NM - 1)) ? '0 : owner + 1'b1;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // gnt is one-hot or zero, so the owner mux collapses to all-zero when idle.
   always_comb begin
      bus.s_stb    = 1'b0;
      bus.s_we     = 1'b0;
      bus.s_adr    = '0;
      bus.s_sel    = '0;
      bus.s_dat_ms = '0;
      for (int i = 0; i < NM; i++) begin
         if (gnt[i]) begin
            bus.s_stb    = (state == GRANT) && bus.m_stb[i];
            bus.s_we     = bus.m_we[i];
            bus.s_adr    = bus.m_adr[i*AW +: AW];
            bus.s_sel    = bus.m_sel[i*4 +: 4];
            bus.s_dat_ms = bus.m_dat_ms[i*32 +: 32];
         end
      end
   end

   assign bus.s_cyc    = (state == GRANT) && |(gnt & bus.m_cyc);
   assign bus.m_ack    = {NM{bus.s_ack}} & gnt;
   assign bus.m_err    = {NM{bus.s_err}} & gnt;
   assign bus.m_dat_sm = bus.s_dat_sm;

`ifdef WSHB_ARB_STATS_EN
   logic [NM-1:0][15:0] stat_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < NM; i++)
            if (state == GRANT && bus.s_ack && gnt[i] && stat_q[i] != 16'hFFFF)
               stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   assign stat_beats = stat_q;
`else
   assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Directed bench for wshb_rr_arbiter: master/slave models drive the bus, a scoreboard
// holds the hand-ordered beat sequence and a monitor checks every acked/erred beat.
module tb_wshb_rr_arbiter;
   localparam int NM = 2;
   localparam int AW = 32;
   localparam int MB = 4;
   localparam logic [31:0] RDK = 32'h5A5A_0F0F;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic [NM-1:0]     gnt;
   logic [NM*16-1:0]  stat;

   wshb_rr_arbiter_if #(.NM(NM), .AW(AW)) bus ();

   wshb_rr_arbiter #(.NM(NM), .AW(AW), .MAX_BURST(MB)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bus        (bus),
      .gnt        (gnt),
      .stat_beats (stat)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          mid;
      logic [31:0] adr;
      logic        we;
      logic        err;
      logic [31:0] dat;
   } exp_t;
   exp_t sbq[$];

   int            nb[NM], beat[NM], thr[NM];
   bit            pend[NM], act[NM];
   int            ackc[NM], errc[NM];
   logic [NM-1:0] done_s;
   int            gacks, err_m, err_k;
   logic          req_prev, resp_prev;
   logic [NM-1:0] gtr[$], rg[$], nz[$];
   int            rl[$];

   function automatic logic [31:0] adr_of(int m, int k);
      return (32'(m + 1) << 28) | 32'(k << 2);
   endfunction

   function automatic logic [31:0] wdat_of(int m, int k);
      return 32'hD000_0000 | 32'(m << 16) | 32'(k);
   endfunction

   task automatic chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
      end
   endtask

   task automatic expect_beat(int m, int k, bit e);
      exp_t x;
      x.mid = m;
      x.adr = adr_of(m, k);
      x.we  = (k % 2 == 1);
      x.err = e;
      x.dat = wdat_of(m, k);
      sbq.push_back(x);
   endtask

   task automatic drive_masters();
      for (int i = 0; i < NM; i++) begin
         bus.m_cyc[i]             = act[i];
         bus.m_stb[i]             = act[i];
         bus.m_we[i]              = act[i] && (beat[i] % 2 == 1);
         bus.m_adr[i*AW +: AW]    = act[i] ? adr_of(i, beat[i]) : '0;
         bus.m_sel[i*4 +: 4]      = act[i] ? 4'hF : 4'h0;
         bus.m_dat_ms[i*32 +: 32] = act[i] ? wdat_of(i, beat[i]) : '0;
      end
   endtask

   task automatic setup();
      sys_rst = 1'b1;
      for (int i = 0; i < NM; i++) begin
         nb[i] = 0; beat[i] = 0; thr[i] = 0; pend[i] = 0; act[i] = 0;
         ackc[i] = 0; errc[i] = 0;
      end
      drive_masters();
      bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_dat_sm = '0;
      req_prev = 1'b0; resp_prev = 1'b0;
      done_s = '0; gacks = 0; err_m = 0; err_k = -1;
      sbq.delete(); gtr.delete();
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic start(int m, int n, int th);
      nb[m] = n; beat[m] = 0; thr[m] = th; pend[m] = 1;
   endtask

   // One clock: masters and slave update after the edge, outputs sampled on the falling edge.
   task automatic cycle();
      logic req_now, rsp;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NM; i++)
         if (act[i] && done_s[i]) begin
            beat[i]++;
            if (beat[i] >= nb[i]) act[i] = 0;
         end
      for (int i = 0; i < NM; i++)
         if (pend[i] && gacks >= thr[i]) begin
            pend[i] = 0;
            act[i]  = 1;
         end
      drive_masters();
      #1;
      req_now = bus.s_cyc & bus.s_stb;
      rsp     = req_now && req_prev && !resp_prev;
      bus.s_ack = 1'b0;
      bus.s_err = 1'b0;
      if (rsp) begin
         if (gnt[err_m] && beat[err_m] == err_k) bus.s_err = 1'b1;
         else                                   bus.s_ack = 1'b1;
      end
      bus.s_dat_sm = bus.s_adr ^ RDK;
      req_prev  = req_now;
      resp_prev = rsp;
      @(negedge sys_clk);
      done_s = bus.m_ack | bus.m_err;
      gacks += $countones(done_s);
      for (int i = 0; i < NM; i++) begin
         ackc[i] += int'(bus.m_ack[i]);
         errc[i] += int'(bus.m_err[i]);
      end
      gtr.push_back(gnt);
   endtask

   task automatic run(string name, int budget);
      bit busy;
      int n = 0;
      do begin
         cycle();
         n++;
         busy = (gnt != '0);
         for (int i = 0; i < NM; i++) busy = busy || act[i] || pend[i];
      end while (busy && n < budget);
      if (busy) begin
         checks++; failures++;
         $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
      end
      chk({name, "_sb_left"}, sbq.size(), 0);
   endtask

   task automatic compress();
      rg.delete(); rl.delete(); nz.delete();
      foreach (gtr[j]) begin
         if (rg.size() == 0 || rg[rg.size()-1] != gtr[j]) begin
            rg.push_back(gtr[j]);
            rl.push_back(1);
         end else begin
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         end
      end
      foreach (rg[j]) if (rg[j] != '0) nz.push_back(rg[j]);
   endtask

   // Monitor: every completed beat is matched against the head of the scoreboard.
   initial begin
      logic [NM-1:0] mv;
      exp_t          x;
      int            mid;
      forever begin
         @(negedge sys_clk);
         mv = bus.m_ack | bus.m_err;
         if (!sys_rst && mv != '0) begin
            mid = 0;
            for (int j = 0; j < NM; j++) if (mv[j]) mid = j;
            chk("beat_onehot", $countones(mv), 1);
            chk("beat_gnt", gnt, mv);
            if (sbq.size() == 0) begin
               checks++; failures++;
               $display("FAIL beat_unexpected: master %0d adr %0h with empty scoreboard", mid, bus.s_adr);
            end else begin
               x = sbq.pop_front();
               chk("beat_mid", mid, x.mid);
               chk("beat_adr", bus.s_adr, x.adr);
               chk("beat_we", bus.s_we, x.we);
               chk("beat_err", bus.m_err[mid], x.err);
               chk("beat_sel", bus.s_sel, 4'hF);
               if (x.we)        chk("beat_wdat", bus.s_dat_ms, x.dat);
               else if (!x.err) chk("beat_rdat", bus.m_dat_sm, x.adr ^ RDK);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NM; i++) begin act[i] = 0; beat[i] = 0; end
      drive_masters();
      bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_dat_sm = '0;
      sys_rst = 1'b1;
      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_scyc", bus.s_cyc, 0);
      chk("rst_sstb", bus.s_stb, 0);
      chk("rst_sadr", bus.s_adr, 0);
      chk("rst_mack", bus.m_ack, 0);
      chk("rst_merr", bus.m_err, 0);
      chk("rst_stat", stat, 0);

      // single master, 10 beats, one-cycle grant latency
      setup();
      start(0, 10, 0);
      for (int k = 0; k < 10; k++) expect_beat(0, k, 0);
      cycle();
      chk("t1_scyc_before", bus.s_cyc, 0);
      cycle();
      chk("t1_scyc_after", bus.s_cyc, 1);
      chk("t1_gnt", gnt, 2'b01);
      run("t1", 200);
      chk("t1_ack0", ackc[0], 10);
      chk("t1_ack1", ackc[1], 0);

      // simultaneous requests: master 0 first, one idle cycle, then master 1
      setup();
      start(0, 2, 0);
      start(1, 2, 0);
      for (int k = 0; k < 2; k++) expect_beat(0, k, 0);
      for (int k = 0; k < 2; k++) expect_beat(1, k, 0);
      run("t2", 100);
      compress();
      chk("t2_nz_runs", nz.size(), 2);
      if (rg.size() >= 4) begin
         chk("t2_first", rg[1], 2'b01);
         chk("t2_gap_gnt", rg[2], 2'b00);
         chk("t2_gap_len", rl[2], 1);
         chk("t2_second", rg[3], 2'b10);
      end else begin
         checks++; failures++;
         $display("FAIL t2_runs: got %0d gnt runs expected at least 4", rg.size());
      end

      // forced release after MAX_BURST beats, master 1 joins at beat 2
      setup();
      start(0, 8, 0);
      start(1, 3, 2);
      for (int k = 0; k < 4; k++) expect_beat(0, k, 0);
      for (int k = 0; k < 3; k++) expect_beat(1, k, 0);
      for (int k = 4; k < 8; k++) expect_beat(0, k, 0);
      run("t3", 200);
      compress();
      chk("t3_nz_runs", nz.size(), 3);
      if (nz.size() == 3) begin
         chk("t3_own0", nz[0], 2'b01);
         chk("t3_own1", nz[1], 2'b10);
         chk("t3_own2", nz[2], 2'b01);
      end

      // lone master past MAX_BURST keeps the grant
      setup();
      start(0, 20, 0);
      for (int k = 0; k < 20; k++) expect_beat(0, k, 0);
      run("t4", 300);
      compress();
      chk("t4_ack0", ackc[0], 20);
      chk("t4_nz_runs", nz.size(), 1);

      // slave error on master 1 beat 3 counts as a beat toward MAX_BURST
      setup();
      err_m = 1; err_k = 2;
      start(1, 5, 0);
      start(0, 2, 2);
      expect_beat(1, 0, 0); expect_beat(1, 1, 0); expect_beat(1, 2, 1); expect_beat(1, 3, 0);
      expect_beat(0, 0, 0); expect_beat(0, 1, 0);
      expect_beat(1, 4, 0);
      run("t5", 200);
      chk("t5_err1", errc[1], 1);
      chk("t5_err0", errc[0], 0);
      chk("t5_ack1", ackc[1], 4);
      chk("t5_ack0", ackc[0], 2);

      // asynchronous reset in the middle of a burst
      setup();
      start(0, 10, 0);
      for (int k = 0; k < 10; k++) expect_beat(0, k, 0);
      begin
         int n = 0;
         while (gacks < 3 && n < 50) begin cycle(); n++; end
      end
      chk("t6_pre_scyc", bus.s_cyc, 1);
      #2 sys_rst = 1'b1;
      #1;
      chk("t6_gnt", gnt, 0);
      chk("t6_scyc", bus.s_cyc, 0);
      chk("t6_mack", bus.m_ack, 0);
      chk("t6_stat", stat, 0);
      act[0] = 0; pend[0] = 0;
      drive_masters();
      bus.s_ack = 1'b0;
      sbq.delete();
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // 7 beats master 0 then 3 beats master 1 for the statistics counters
      setup();
      start(0, 7, 0);
      start(1, 3, 7);
      for (int k = 0; k < 7; k++) expect_beat(0, k, 0);
      for (int k = 0; k < 3; k++) expect_beat(1, k, 0);
      run("t7", 200);
`ifdef WSHB_ARB_STATS_EN
      chk("t7_stat", stat, {16'd3, 16'd7});
`else
      chk("t7_stat", stat, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
